// File: rtl/liteeth_sram_1rw1r_param_if.sv
// Port bundle for the 1RW+1R buffer SRAM model.
// master: buffer address generator / datapath side. slave: the SRAM.
interface liteeth_sram_1rw1r_param_if #(
  parameter int BITS       = 42,
  parameter int ADDR_WIDTH = 5,
  parameter int NLANES     = 6
);
  logic                  csb0;
  logic                  web0;
  logic [NLANES-1:0]     wmask0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [BITS-1:0]       din0;
  logic [BITS-1:0]       dout0;
  logic                  dout0_valid;
  logic                  csb1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [BITS-1:0]       dout1;
  logic                  dout1_valid;
  logic                  addr_err;
  logic                  par_err0;
  logic                  par_err1;

  modport master (
    output csb0, web0, wmask0, addr0, din0, csb1, addr1,
    input  dout0, dout0_valid, dout1, dout1_valid, addr_err, par_err0, par_err1
  );

  modport slave (
    input  csb0, web0, wmask0, addr0, din0, csb1, addr1,
    output dout0, dout0_valid, dout1, dout1_valid, addr_err, par_err0, par_err1
  );
endinterface

// File: rtl/liteeth_sram_1rw1r_param.sv
// Parametrised single-clock 1RW+1R SRAM model for LiteEth MAC buffers and
// descriptor stores. Port 0 is read-first with per-lane write masking; port 1
// is read-only. Read latency is 1 cycle, or 2 with OUT_REG=1. Out-of-range
// accesses read zero, drop writes and set a sticky addr_err.
// Optional per-lane even parity: define LITEETH_SRAM_PARITY_EN.
module liteeth_sram_1rw1r_param #(
  parameter int BITS         = 42,
  parameter int WORD_DEPTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int LANE_BITS    = 8,
  parameter int OUT_REG      = 0,
  parameter int COLLISION_WT = 0
) (
  input logic                        clk,
  input logic                        rst_n,
  liteeth_sram_1rw1r_param_if.slave  bus
);

  localparam int NLANES = (BITS + LANE_BITS - 1) / LANE_BITS;
  localparam int IDX_W  = (WORD_DEPTH > 1) ? $clog2(WORD_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(WORD_DEPTH);

  // Array contents are deliberately not reset.
  logic [WORD_DEPTH-1:0][BITS-1:0] mem_q, mem_d;

  logic [IDX_W-1:0] idx0, idx1;
  logic             acc0, acc1;
  logic             in0, in1;
  logic             we0, fwd1;
  logic [BITS-1:0]  bm0;
  logic [BITS-1:0]  old0, wr_word0;
  logic [BITS-1:0]  rd0, rd1;
  logic             pe0, pe1;

  // First pipeline stage and sticky error flag
  logic            v0_s1_q, v0_s1_d, v1_s1_q, v1_s1_d;
  logic [BITS-1:0] d0_s1_q, d0_s1_d, d1_s1_q, d1_s1_d;
  logic            pe0_s1_q, pe0_s1_d, pe1_s1_q, pe1_s1_d;
  logic            addr_err_q, addr_err_d;

  assign acc0 = ~bus.csb0;
  assign acc1 = ~bus.csb1;
  assign in0  = ({1'b0, bus.addr0} < DEPTH_C);
  assign in1  = ({1'b0, bus.addr1} < DEPTH_C);
  assign idx0 = bus.addr0[IDX_W-1:0];
  assign idx1 = bus.addr1[IDX_W-1:0];

  // Expand lane enables to a bit mask; bits of a partial last lane past BITS
  // simply do not exist, so its unused mask span is ignored.
  genvar gi;
  generate
    for (gi = 0; gi < BITS; gi++) begin : g_bm
      assign bm0[gi] = bus.wmask0[gi / LANE_BITS];
    end
  endgenerate

  assign we0      = acc0 & ~bus.web0 & in0;
  assign old0     = mem_q[idx0];
  assign wr_word0 = (old0 & ~bm0) | (bus.din0 & bm0);
  assign fwd1     = (COLLISION_WT != 0) & we0 & in1 & (idx1 == idx0);

  // Port 0 is always read-first; port 1 sees the merged word only when forwarding
  assign rd0 = in0 ? old0 : '0;
  assign rd1 = !in1 ? '0 : (fwd1 ? wr_word0 : mem_q[idx1]);

  // Next array contents: masked write of port 0
  always_comb begin
    mem_d = mem_q;
    if (we0) begin
      mem_d[idx0] = wr_word0;
    end
  end

  // Array storage, no reset
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef LITEETH_SRAM_PARITY_EN
  logic [WORD_DEPTH-1:0][NLANES-1:0] par_q, par_d;
  logic [NLANES-1:0] par_w, par_rd0, par_rd1, par_wr, par_st1;

  genvar gk;
  generate
    for (gk = 0; gk < NLANES; gk++) begin : g_par
      localparam int LO = gk * LANE_BITS;
      localparam int HI = (LO + LANE_BITS > BITS) ? BITS - 1 : LO + LANE_BITS - 1;
      assign par_w[gk]   = ^bus.din0[HI:LO];
      assign par_rd0[gk] = ^rd0[HI:LO];
      assign par_rd1[gk] = ^rd1[HI:LO];
    end
  endgenerate

  assign par_wr  = (par_q[idx0] & ~bus.wmask0) | (par_w & bus.wmask0);
  assign par_st1 = fwd1 ? par_wr : par_q[idx1];
  assign pe0     = in0 & (par_rd0 != par_q[idx0]);
  assign pe1     = in1 & (par_rd1 != par_st1);

  // Next parity contents: only the written lanes take fresh parity
  always_comb begin
    par_d = par_q;
    if (we0) begin
      par_d[idx0] = par_wr;
    end
  end

  // Parity storage, no reset
  always_ff @(posedge clk) begin
    par_q <= par_d;
  end
`else
  assign pe0 = 1'b0;
  assign pe1 = 1'b0;
`endif

  // Stage 1 next state: data moves only with a valid access, strobes pulse
  always_comb begin
    v0_s1_d    = acc0;
    v1_s1_d    = acc1;
    d0_s1_d    = acc0 ? rd0 : d0_s1_q;
    d1_s1_d    = acc1 ? rd1 : d1_s1_q;
    pe0_s1_d   = acc0 & pe0;
    pe1_s1_d   = acc1 & pe1;
    addr_err_d = addr_err_q | (acc0 & ~in0) | (acc1 & ~in1);
  end

  // Stage 1 registers and sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_s1_q    <= 1'b0;
      v1_s1_q    <= 1'b0;
      d0_s1_q    <= '0;
      d1_s1_q    <= '0;
      pe0_s1_q   <= 1'b0;
      pe1_s1_q   <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      v0_s1_q    <= v0_s1_d;
      v1_s1_q    <= v1_s1_d;
      d0_s1_q    <= d0_s1_d;
      d1_s1_q    <= d1_s1_d;
      pe0_s1_q   <= pe0_s1_d;
      pe1_s1_q   <= pe1_s1_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign bus.addr_err = addr_err_q;

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic            v0_s2_q, v0_s2_d, v1_s2_q, v1_s2_d;
      logic [BITS-1:0] d0_s2_q, d0_s2_d, d1_s2_q, d1_s2_d;
      logic            pe0_s2_q, pe0_s2_d, pe1_s2_q, pe1_s2_d;

      // Stage 2 next state: loads only when stage 1 holds a valid word
      always_comb begin
        v0_s2_d  = v0_s1_q;
        v1_s2_d  = v1_s1_q;
        d0_s2_d  = v0_s1_q ? d0_s1_q : d0_s2_q;
        d1_s2_d  = v1_s1_q ? d1_s1_q : d1_s2_q;
        pe0_s2_d = v0_s1_q & pe0_s1_q;
        pe1_s2_d = v1_s1_q & pe1_s1_q;
      end

      // Stage 2 output registers
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v0_s2_q  <= 1'b0;
          v1_s2_q  <= 1'b0;
          d0_s2_q  <= '0;
          d1_s2_q  <= '0;
          pe0_s2_q <= 1'b0;
          pe1_s2_q <= 1'b0;
        end else begin
          v0_s2_q  <= v0_s2_d;
          v1_s2_q  <= v1_s2_d;
          d0_s2_q  <= d0_s2_d;
          d1_s2_q  <= d1_s2_d;
          pe0_s2_q <= pe0_s2_d;
          pe1_s2_q <= pe1_s2_d;
        end
      end

      assign bus.dout0       = d0_s2_q;
      assign bus.dout1       = d1_s2_q;
      assign bus.dout0_valid = v0_s2_q;
      assign bus.dout1_valid = v1_s2_q;
      assign bus.par_err0    = pe0_s2_q;
      assign bus.par_err1    = pe1_s2_q;
    end else begin : g_no_out_reg
      assign bus.dout0       = d0_s1_q;
      assign bus.dout1       = d1_s1_q;
      assign bus.dout0_valid = v0_s1_q;
      assign bus.dout1_valid = v1_s1_q;
      assign bus.par_err0    = pe0_s1_q;
      assign bus.par_err1    = pe1_s1_q;
    end
  endgenerate

endmodule

// File: tb/tb_liteeth_sram_1rw1r_param.sv
// Bench for liteeth_sram_1rw1r_param. Two instances share one stimulus:
//   dut_a: WORD_DEPTH=20, OUT_REG=0, COLLISION_WT=0
//   dut_b: WORD_DEPTH=32, OUT_REG=1, COLLISION_WT=1
// Expected values come from a word-array model with a per-port delay queue.
module tb_liteeth_sram_1rw1r_param;
  localparam int BITS = 42;
  localparam int AW   = 5;
  localparam int NL   = 6;
`ifdef LITEETH_SRAM_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  typedef struct packed {
    logic            v;
    logic            chk;
    logic            pe;
    logic [BITS-1:0] d;
  } item_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  logic            c0, w0, c1;
  logic [NL-1:0]   m0;
  logic [AW-1:0]   a0, a1;
  logic [BITS-1:0] d0;

  logic [BITS-1:0] mm [2][32];
  bit              kn [2][32];
  item_t           pq [4][$];
  logic [BITS-1:0] held [4];
  bit              hchk [4];
  bit              aerr [2];
  bit              corrupt9;
  int              depth_c [2] = '{20, 32};
  bit              wt_c [2]    = '{1'b0, 1'b1};
  int              lat_c [2]   = '{1, 2};

  always #5 clk = ~clk;

  liteeth_sram_1rw1r_param_if #(.BITS(BITS), .ADDR_WIDTH(AW), .NLANES(NL)) bus_a ();
  liteeth_sram_1rw1r_param_if #(.BITS(BITS), .ADDR_WIDTH(AW), .NLANES(NL)) bus_b ();

  assign bus_a.csb0 = c0;  assign bus_b.csb0 = c0;
  assign bus_a.web0 = w0;  assign bus_b.web0 = w0;
  assign bus_a.wmask0 = m0; assign bus_b.wmask0 = m0;
  assign bus_a.addr0 = a0; assign bus_b.addr0 = a0;
  assign bus_a.din0 = d0;  assign bus_b.din0 = d0;
  assign bus_a.csb1 = c1;  assign bus_b.csb1 = c1;
  assign bus_a.addr1 = a1; assign bus_b.addr1 = a1;

  liteeth_sram_1rw1r_param #(
    .BITS(BITS), .WORD_DEPTH(20), .ADDR_WIDTH(AW), .LANE_BITS(8),
    .OUT_REG(0), .COLLISION_WT(0)
  ) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));

  liteeth_sram_1rw1r_param #(
    .BITS(BITS), .WORD_DEPTH(32), .ADDR_WIDTH(AW), .LANE_BITS(8),
    .OUT_REG(1), .COLLISION_WT(1)
  ) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  function automatic logic [BITS-1:0] lane_bits(input logic [NL-1:0] m);
    logic [BITS-1:0] r;
    r = '0;
    for (int k = 0; k < NL; k++)
      if (((m >> k) & 6'd1) != 6'd0) r = r | (42'hFF << (8 * k));
    return r;
  endfunction

  function automatic logic obs_v(input int p);
    case (p)
      0: return bus_a.dout0_valid;
      1: return bus_a.dout1_valid;
      2: return bus_b.dout0_valid;
      default: return bus_b.dout1_valid;
    endcase
  endfunction

  function automatic logic [BITS-1:0] obs_d(input int p);
    case (p)
      0: return bus_a.dout0;
      1: return bus_a.dout1;
      2: return bus_b.dout0;
      default: return bus_b.dout1;
    endcase
  endfunction

  function automatic logic obs_pe(input int p);
    case (p)
      0: return bus_a.par_err0;
      1: return bus_a.par_err1;
      2: return bus_b.par_err0;
      default: return bus_b.par_err1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic c0_i, input logic w0_i, input logic [NL-1:0] m0_i,
                        input logic [AW-1:0] a0_i, input logic [BITS-1:0] d0_i,
                        input logic c1_i, input logic [AW-1:0] a1_i);
    c0 = c0_i; w0 = w0_i; m0 = m0_i; a0 = a0_i; d0 = d0_i; c1 = c1_i; a1 = a1_i;
  endtask

  task automatic set_idle();
    set_in(1'b1, 1'b1, '0, '0, '0, 1'b1, '0);
  endtask

  task automatic model_reset();
    item_t nil;
    nil = '0;
    for (int p = 0; p < 4; p++) begin
      pq[p].delete();
      held[p] = '0;
      hchk[p] = 1'b1;
      if (lat_c[p / 2] == 2) pq[p].push_back(nil);
    end
    aerr[0] = 1'b0;
    aerr[1] = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("%s_v%0d", tag, p), {63'd0, obs_v(p)}, 64'd0);
      chk($sformatf("%s_d%0d", tag, p), {22'd0, obs_d(p)}, 64'd0);
      chk($sformatf("%s_pe%0d", tag, p), {63'd0, obs_pe(p)}, 64'd0);
    end
    chk($sformatf("%s_aerr_a", tag), {63'd0, bus_a.addr_err}, 64'd0);
    chk($sformatf("%s_aerr_b", tag), {63'd0, bus_b.addr_err}, 64'd0);
  endtask

  // One clock: evaluate the model on current inputs, advance, compare outputs.
  task automatic tick();
    item_t it0, it1, o;
    logic [BITS-1:0] bm;
    bit in0, in1, we, fwd;
    bm = lane_bits(m0);
    for (int u = 0; u < 2; u++) begin
      in0 = (int'(a0) < depth_c[u]);
      in1 = (int'(a1) < depth_c[u]);
      we  = !c0 && !w0 && in0;
      fwd = wt_c[u] && we && in1 && (a1 == a0);
      it0 = '0;
      it1 = '0;
      it0.v   = !c0;
      it0.d   = in0 ? mm[u][a0] : '0;
      it0.chk = !in0 || kn[u][a0];
      it0.pe  = PAR_ON && (u == 0) && corrupt9 && in0 && (a0 == 5'd9);
      it1.v   = !c1;
      it1.d   = !in1 ? '0 : (fwd ? ((mm[u][a1] & ~bm) | (d0 & bm)) : mm[u][a1]);
      it1.chk = !in1 || kn[u][a1];
      it1.pe  = PAR_ON && (u == 0) && corrupt9 && in1 && (a1 == 5'd9) && !(fwd && m0[2]);
      if ((!c0 && !in0) || (!c1 && !in1)) aerr[u] = 1'b1;
      if (we) begin
        mm[u][a0] = (mm[u][a0] & ~bm) | (d0 & bm);
        if (m0 == 6'h3F) kn[u][a0] = 1'b1;
        if (u == 0 && a0 == 5'd9 && m0[2]) corrupt9 = 1'b0;
      end
      pq[2*u].push_back(it0);
      pq[2*u+1].push_back(it1);
    end
    @(posedge clk);
    @(negedge clk);
    for (int p = 0; p < 4; p++) begin
      o = pq[p].pop_front();
      if (o.v) begin
        held[p] = o.d;
        hchk[p] = o.chk;
      end
      chk($sformatf("valid%0d", p), {63'd0, obs_v(p)}, {63'd0, o.v});
      if (hchk[p]) chk($sformatf("dout%0d", p), {22'd0, obs_d(p)}, {22'd0, held[p]});
      if (o.chk || !o.v) chk($sformatf("par_err%0d", p), {63'd0, obs_pe(p)}, {63'd0, o.v & o.pe});
    end
    chk("addr_err_a", {63'd0, bus_a.addr_err}, {63'd0, aerr[0]});
    chk("addr_err_b", {63'd0, bus_b.addr_err}, {63'd0, aerr[1]});
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    set_idle();
    #1;
    check_zero(tag);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int vcnt;
    logic [BITS-1:0] rd;
    set_idle();
    corrupt9 = 1'b0;
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 32; i++) kn[u][i] = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // basic write then port 1 read
    set_in(1'b0, 1'b0, 6'h3F, 5'd3, 42'h2AB_CDEF_0123, 1'b1, 5'd0); tick();
    set_in(1'b1, 1'b1, 6'h00, 5'd0, '0, 1'b0, 5'd3); tick();
    chk("t1_dout1", {22'd0, bus_a.dout1}, {22'd0, 42'h2AB_CDEF_0123});
    chk("t1_valid1", {63'd0, bus_a.dout1_valid}, 64'd1);
    set_idle(); tick();
    chk("t1_valid1_pulse", {63'd0, bus_a.dout1_valid}, 64'd0);
    chk("t1_dout1_b", {22'd0, bus_b.dout1}, {22'd0, 42'h2AB_CDEF_0123});

    // masked write
    set_in(1'b0, 1'b0, 6'h3F, 5'd5, 42'h3FF_FFFF_FFFF, 1'b1, 5'd0); tick();
    set_in(1'b0, 1'b0, 6'b000001, 5'd5, 42'h0, 1'b1, 5'd0); tick();
    set_in(1'b1, 1'b1, 6'h00, 5'd0, '0, 1'b0, 5'd5); tick();
    chk("mask_a", {22'd0, bus_a.dout1}, {22'd0, 42'h3FF_FFFF_FF00});
    set_idle(); tick();
    chk("mask_b", {22'd0, bus_b.dout1}, {22'd0, 42'h3FF_FFFF_FF00});

    // collision at address 7
    set_in(1'b0, 1'b0, 6'h3F, 5'd7, 42'h11, 1'b1, 5'd0); tick();
    set_in(1'b0, 1'b0, 6'h3F, 5'd7, 42'h22, 1'b0, 5'd7); tick();
    chk("col_a_dout1", {22'd0, bus_a.dout1}, 64'h11);
    chk("col_a_dout0", {22'd0, bus_a.dout0}, 64'h11);
    set_idle(); tick();
    chk("col_b_dout1", {22'd0, bus_b.dout1}, 64'h22);
    chk("col_b_dout0", {22'd0, bus_b.dout0}, 64'h11);

    // out of range on dut_a (depth 20)
    chk("oor_aerr_pre", {63'd0, bus_a.addr_err}, 64'd0);
    set_in(1'b0, 1'b1, 6'h00, 5'd25, '0, 1'b0, 5'd25); tick();
    chk("oor_dout1", {22'd0, bus_a.dout1}, 64'd0);
    chk("oor_valid1", {63'd0, bus_a.dout1_valid}, 64'd1);
    chk("oor_dout0", {22'd0, bus_a.dout0}, 64'd0);
    chk("oor_aerr", {63'd0, bus_a.addr_err}, 64'd1);
    set_in(1'b0, 1'b0, 6'h3F, 5'd25, 42'h0, 1'b1, 5'd0); tick();
    set_in(1'b1, 1'b1, 6'h00, 5'd0, '0, 1'b0, 5'd5); tick();
    chk("oor_keep5", {22'd0, bus_a.dout1}, {22'd0, 42'h3FF_FFFF_FF00});
    set_idle(); tick();
    chk("oor_aerr_sticky", {63'd0, bus_a.addr_err}, 64'd1);
    do_reset("aerr_clr");

    // fill every address, then random traffic
    for (int i = 0; i < 32; i++) begin
      set_in(1'b0, 1'b0, 6'h3F, 5'(i), 42'({$urandom(), $urandom()}), 1'b1, 5'd0);
      tick();
    end
    for (int n = 0; n < 300; n++) begin
      logic [AW-1:0] ra0;
      ra0 = 5'($urandom_range(0, 31));
      set_in(($urandom_range(0, 3) == 0), 1'($urandom()), 6'($urandom()), ra0,
             42'({$urandom(), $urandom()}), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) == 0) ? ra0 : 5'($urandom_range(0, 31)));
      tick();
    end
    do_reset("rand_end");

    // back-to-back burst through the 2-stage pipe
    vcnt = 0;
    rd = mm[1][0];
    for (int i = 0; i < 5; i++) begin
      if (i < 3) set_in(1'b0, 1'b1, 6'h00, 5'(i), '0, 1'b0, 5'(i));
      else set_idle();
      tick();
      if (bus_b.dout1_valid) vcnt++;
      if (i == 1) chk("burst_first", {22'd0, bus_b.dout1}, {22'd0, rd});
    end
    chk("burst_vcnt", 64'(vcnt), 64'd3);

    // reset in the middle of a burst
    set_in(1'b0, 1'b1, 6'h00, 5'd0, '0, 1'b0, 5'd0); tick();
    set_in(1'b0, 1'b1, 6'h00, 5'd1, '0, 1'b0, 5'd1); tick();
    set_in(1'b0, 1'b1, 6'h00, 5'd2, '0, 1'b0, 5'd2);
    #2;
    do_reset("midrst");
    repeat (3) tick();

    // parity: flip one bit of lane 2 in word 9 of dut_a
    set_in(1'b0, 1'b0, 6'h3F, 5'd9, 42'h155_5555_5555, 1'b1, 5'd0); tick();
    force dut_a.mem_q[9][16] = 1'b0;
    mm[0][9][16] = 1'b0;
    corrupt9 = 1'b1;
    set_in(1'b1, 1'b1, 6'h00, 5'd0, '0, 1'b0, 5'd9); tick();
    chk("par_err1", {63'd0, bus_a.par_err1}, {63'd0, PAR_ON});
    chk("par_valid1", {63'd0, bus_a.dout1_valid}, 64'd1);
    chk("par_dout1", {22'd0, bus_a.dout1}, {22'd0, 42'h155_5554_5555});
    set_in(1'b0, 1'b1, 6'h00, 5'd9, '0, 1'b1, 5'd0); tick();
    set_idle(); tick();
    chk("par_err1_idle", {63'd0, bus_a.par_err1}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
